// File: rtl/adc_code_decimator.sv
// Frame accumulator/decimator behind the flash ADC encoder: sums 2**LOG2_N codes,
// presents sum and truncated mean on a single-entry valid/ready output register.
module adc_code_decimator #(
    parameter int CODE_W = 4,
    parameter int LOG2_N = 3,
    parameter int FCNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     b_valid,
    input  logic [CODE_W-1:0]        b,
    input  logic                     flush,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [CODE_W+LOG2_N-1:0] out_sum,
    output logic [CODE_W-1:0]        out_avg,
    output logic                     overrun,
    input  logic                     ovr_clr,
    output logic [FCNT_W-1:0]        frame_cnt
);

    localparam int SUM_W = CODE_W + LOG2_N;

    logic [SUM_W-1:0]  acc_q, acc_d;
    logic [LOG2_N-1:0] cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [SUM_W-1:0]  out_sum_q, out_sum_d;
    logic [CODE_W-1:0] out_avg_q, out_avg_d;
    logic              overrun_q, overrun_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic              take;
    logic              done;
    logic              load_ok;
    logic              load;
    logic              drop;
    logic [SUM_W-1:0]  new_sum;

    assign take    = en & b_valid & ~flush;
    // cnt counts 0..N-1, so the Nth sample arrives while cnt is all ones
    assign done    = take & (cnt_q == '1);
    assign new_sum = acc_q + SUM_W'(b);
    assign load_ok = ~out_valid_q | out_ready;
    assign load    = done & load_ok;
    assign drop    = done & ~load_ok;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (flush || done) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (take) begin
            acc_d = new_sum;
            cnt_d = cnt_q + LOG2_N'(1);
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_avg_d   = out_avg_q;
        frame_cnt_d = frame_cnt_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_sum_d   = new_sum;
            out_avg_d   = new_sum[SUM_W-1 -: CODE_W];
            frame_cnt_d = frame_cnt_q + FCNT_W'(1);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // a drop in the same cycle as a clear must leave the flag set
    always_comb begin
        overrun_d = overrun_q;
        if (drop)
            overrun_d = 1'b1;
        else if (ovr_clr)
            overrun_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_avg_q   <= '0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_avg_q   <= out_avg_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_avg   = out_avg_q;
    assign overrun   = overrun_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_adc_code_decimator.sv
// Bench for adc_code_decimator: constant-code frame table, directed corner
// sequences, then random traffic against a queue-based frame model.
module tb_adc_code_decimator;

    localparam int CODE_W = 4;
    localparam int LOG2_N = 3;
    localparam int FCNT_W = 16;
    localparam int N      = 1 << LOG2_N;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     en = 1'b0;
    logic                     b_valid = 1'b0;
    logic [CODE_W-1:0]        b = '0;
    logic                     flush = 1'b0;
    logic                     out_ready = 1'b0;
    logic                     out_valid;
    logic [CODE_W+LOG2_N-1:0] out_sum;
    logic [CODE_W-1:0]        out_avg;
    logic                     overrun;
    logic                     ovr_clr = 1'b0;
    logic [FCNT_W-1:0]        frame_cnt;

    int checks = 0;
    int failures = 0;

    adc_code_decimator #(.CODE_W(CODE_W), .LOG2_N(LOG2_N), .FCNT_W(FCNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .b_valid(b_valid), .b(b), .flush(flush),
        .out_ready(out_ready), .out_valid(out_valid), .out_sum(out_sum),
        .out_avg(out_avg), .overrun(overrun), .ovr_clr(ovr_clr), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int code;
        int exp_sum;
        int exp_avg;
    } frame_vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // one clock edge; outputs are stable 1 time unit later
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; en = 0; b_valid = 0; b = '0; flush = 0; ovr_clr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        cyc();
        rst = 0;
    endtask

    task automatic take(input int code);
        en = 1; b_valid = 1; b = CODE_W'(code);
        cyc();
        en = 0; b_valid = 0;
    endtask

    task automatic takes(input int code, input int n);
        for (int i = 0; i < n; i++) take(code);
    endtask

    // reference model state
    int m_q[$];
    int m_valid, m_sum, m_avg, m_ovr, m_fcnt;

    task automatic model_step(input int r, input int e, input int bv, input int code,
                              input int fl, input int rdy, input int clr);
        int loaded, dropped, s;
        loaded = 0; dropped = 0;
        if (r != 0) begin
            m_q.delete();
            m_valid = 0; m_sum = 0; m_avg = 0; m_ovr = 0; m_fcnt = 0;
            return;
        end
        if (fl != 0) begin
            m_q.delete();
        end else if (e != 0 && bv != 0) begin
            m_q.push_back(code);
            if (m_q.size() == N) begin
                s = m_q.sum();
                m_q.delete();
                if (m_valid == 0 || rdy != 0) begin
                    m_sum = s; m_avg = s / N; m_valid = 1;
                    m_fcnt = (m_fcnt + 1) % (1 << FCNT_W);
                    loaded = 1;
                end else begin
                    dropped = 1;
                    m_ovr = 1;
                end
            end
        end
        if (loaded == 0 && m_valid != 0 && rdy != 0) m_valid = 0;
        if (clr != 0 && dropped == 0) m_ovr = 0;
    endtask

    frame_vec_t tbl[6];

    initial begin
        tbl[0] = '{code: 15, exp_sum: 120, exp_avg: 15};
        tbl[1] = '{code: 0,  exp_sum: 0,   exp_avg: 0};
        tbl[2] = '{code: 4,  exp_sum: 32,  exp_avg: 4};
        tbl[3] = '{code: 9,  exp_sum: 72,  exp_avg: 9};
        tbl[4] = '{code: 1,  exp_sum: 8,   exp_avg: 1};
        tbl[5] = '{code: 7,  exp_sum: 56,  exp_avg: 7};

        idle_inputs();
        out_ready = 0;
        cyc();
        do_reset();
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_sum", int'(out_sum), 0);
        chk("reset_avg", int'(out_avg), 0);
        chk("reset_ovr", int'(overrun), 0);
        chk("reset_fcnt", int'(frame_cnt), 0);

        // constant-code frames: latency and arithmetic
        foreach (tbl[i]) begin
            do_reset();
            out_ready = 0;
            takes(tbl[i].code, N - 1);
            chk("tbl_valid_early", int'(out_valid), 0);
            take(tbl[i].code);
            chk("tbl_valid", int'(out_valid), 1);
            chk("tbl_sum", int'(out_sum), tbl[i].exp_sum);
            chk("tbl_avg", int'(out_avg), tbl[i].exp_avg);
            chk("tbl_fcnt", int'(frame_cnt), 1);
        end

        // ramp with ready held high: one-cycle valid pulse
        do_reset();
        out_ready = 1;
        for (int i = 0; i < N; i++) take(i);
        chk("ramp_valid", int'(out_valid), 1);
        chk("ramp_sum", int'(out_sum), 28);
        chk("ramp_avg", int'(out_avg), 3);
        cyc();
        chk("ramp_valid_drop", int'(out_valid), 0);
        chk("ramp_sum_hold", int'(out_sum), 28);
        out_ready = 0;
        cyc();
        chk("ramp_valid_stays0", int'(out_valid), 0);

        // held frame, second frame dropped
        do_reset();
        out_ready = 0;
        takes(4, N);
        chk("ovr_first_sum", int'(out_sum), 32);
        takes(4, N);
        chk("ovr_set", int'(overrun), 1);
        chk("ovr_sum_held", int'(out_sum), 32);
        chk("ovr_fcnt", int'(frame_cnt), 1);
        chk("ovr_valid", int'(out_valid), 1);
        ovr_clr = 1; cyc(); ovr_clr = 0;
        chk("ovr_clr", int'(overrun), 0);

        // consume and reload on the same edge
        do_reset();
        out_ready = 0;
        takes(2, N);
        chk("b2b_sum1", int'(out_sum), 16);
        takes(3, N - 1);
        out_ready = 1;
        take(3);
        chk("b2b_valid", int'(out_valid), 1);
        chk("b2b_sum2", int'(out_sum), 24);
        chk("b2b_fcnt", int'(frame_cnt), 2);
        chk("b2b_ovr", int'(overrun), 0);
        cyc();
        chk("b2b_drain", int'(out_valid), 0);

        // pause with en=0 while b_valid stays high
        do_reset();
        out_ready = 0;
        takes(9, 5);
        en = 0; b_valid = 1; b = 4'd9;
        for (int i = 0; i < 10; i++) cyc();
        b_valid = 0;
        chk("pause_valid", int'(out_valid), 0);
        takes(9, 3);
        chk("pause_sum", int'(out_sum), 72);
        chk("pause_avg", int'(out_avg), 9);

        // flush discards partial frame, keeps held output
        takes(15, 4);
        en = 1; b_valid = 1; b = 4'd15; flush = 1;
        cyc();
        idle_inputs();
        chk("flush_sum_kept", int'(out_sum), 72);
        chk("flush_fcnt_kept", int'(frame_cnt), 1);
        takes(1, N - 1);
        chk("flush_no_drop", int'(overrun), 0);
        chk("flush_still_72", int'(out_sum), 72);
        out_ready = 1;
        take(1);
        chk("flush_sum", int'(out_sum), 8);
        chk("flush_fcnt", int'(frame_cnt), 2);

        // reset mid-frame wins over a same-cycle sample
        out_ready = 0;
        takes(15, 4);
        en = 1; b_valid = 1; b = 4'd15; rst = 1;
        cyc();
        idle_inputs();
        chk("rst_mid_valid", int'(out_valid), 0);
        chk("rst_mid_sum", int'(out_sum), 0);
        chk("rst_mid_fcnt", int'(frame_cnt), 0);
        takes(2, N - 1);
        chk("rst_mid_early", int'(out_valid), 0);
        take(2);
        chk("rst_mid_sum2", int'(out_sum), 16);
        chk("rst_mid_fcnt2", int'(frame_cnt), 1);

        // drop and clear in the same cycle: set wins
        takes(5, N - 1);
        ovr_clr = 1;
        take(5);
        ovr_clr = 0;
        chk("ovr_set_wins", int'(overrun), 1);
        chk("ovr_set_sum", int'(out_sum), 16);
        ovr_clr = 1; cyc(); ovr_clr = 0;
        chk("ovr_clr2", int'(overrun), 0);

        // random traffic against the frame model
        do_reset();
        model_step(1, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            en        = ($urandom_range(0, 9) < 8);
            b_valid   = ($urandom_range(0, 9) < 7);
            b         = CODE_W'($urandom_range(0, (1 << CODE_W) - 1));
            flush     = ($urandom_range(0, 39) == 0);
            out_ready = ($urandom_range(0, 1) == 1);
            ovr_clr   = ($urandom_range(0, 19) == 0);
            cyc();
            model_step(int'(rst), int'(en), int'(b_valid), int'(b), int'(flush),
                       int'(out_ready), int'(ovr_clr));
            chk("rnd_valid", int'(out_valid), m_valid);
            chk("rnd_sum", int'(out_sum), m_sum);
            chk("rnd_avg", int'(out_avg), m_avg);
            chk("rnd_ovr", int'(overrun), m_ovr);
            chk("rnd_fcnt", int'(frame_cnt), m_fcnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
